// File: rtl/muldiv_writeback_unit.sv
// Iterative MUL/UMULH/UDIV/SDIV unit writing its result straight into the register file.
// SDIV sign handling is built only when MULDIV_SDIV_EN is defined; otherwise op=11 behaves as UDIV.
module muldiv_writeback_unit #(
    parameter int unsigned N = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [4:0]   dest,
    output logic         busy,
    output logic [N-1:0] wb_data,
    output logic [4:0]   wb_addr,
    output logic         wb_write
);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic [1:0]     op_q;
    logic [4:0]     dest_q;
    logic [N-1:0]   opnd_q;
    logic [N-1:0]   acc_hi;
    logic [N-1:0]   acc_lo;
    logic           dz_q;
`ifdef MULDIV_SDIV_EN
    logic           neg_q;
`endif

    logic           accept;
    logic           last;
    logic [N-1:0]   a_in;
    logic [N-1:0]   b_in;
    logic [N:0]     mul_sum;
    logic [N:0]     shifted;
    logic           div_ge;
    logic [N-1:0]   step_hi;
    logic [N-1:0]   step_lo;
    logic [N-1:0]   quot;
    logic [N-1:0]   result;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Issue operands: SDIV works on magnitudes
    always_comb begin
        a_in = a;
        b_in = b;
`ifdef MULDIV_SDIV_EN
        if (op == 2'b11) begin
            if (a[N-1]) a_in = {N{1'b0}} - a;
            if (b[N-1]) b_in = {N{1'b0}} - b;
        end
`endif
    end

    // One iteration step and the final result selection
    always_comb begin
        accept  = (state == IDLE) && start;
        last    = (state == RUN) && (cnt == LAST);
        mul_sum = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opnd_q}) : {1'b0, acc_hi};
        shifted = {acc_hi, acc_lo[N-1]};
        div_ge  = shifted >= {1'b0, opnd_q};
        if (op_q[1]) begin
            // Remainder stays below the divisor, so the N-bit difference is exact.
            step_hi = div_ge ? (shifted[N-1:0] - opnd_q) : shifted[N-1:0];
            step_lo = {acc_lo[N-2:0], div_ge};
        end else begin
            step_hi = mul_sum[N:1];
            step_lo = {mul_sum[0], acc_lo[N-1:1]};
        end
        quot = step_lo;
`ifdef MULDIV_SDIV_EN
        if (neg_q) quot = {N{1'b0}} - step_lo;
`endif
        if (op_q[1]) begin
            result = dz_q ? {N{1'b0}} : quot;
        end else begin
            result = op_q[0] ? step_hi : step_lo;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            op_q     <= '0;
            dest_q   <= '0;
            opnd_q   <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            dz_q     <= 1'b0;
`ifdef MULDIV_SDIV_EN
            neg_q    <= 1'b0;
`endif
            busy     <= 1'b0;
            wb_write <= 1'b0;
            wb_data  <= '0;
            wb_addr  <= '0;
        end else begin
            busy     <= (state_next != IDLE);
            wb_write <= (state_next == DONE);
            if (accept) begin
                cnt    <= '0;
                op_q   <= op;
                dest_q <= dest;
                acc_hi <= '0;
                dz_q   <= (b == {N{1'b0}});
`ifdef MULDIV_SDIV_EN
                neg_q  <= (op == 2'b11) && (a[N-1] ^ b[N-1]);
`endif
                if (op[1]) begin
                    acc_lo <= a_in;
                    opnd_q <= b_in;
                end else begin
                    acc_lo <= b;
                    opnd_q <= a;
                end
            end else if (state == RUN) begin
                cnt    <= cnt + CW'(1);
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                if (last) begin
                    wb_data <= result;
                    wb_addr <= dest_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_writeback_unit.sv
// Self-checking bench for muldiv_writeback_unit: scoreboard of expected writebacks plus
// latency, busy, ignored-start, back-to-back and abort scenarios.
module tb_muldiv_writeback_unit;
    localparam int unsigned N = 64;
    localparam int unsigned LAT = 64;

    typedef struct packed {
        logic [N-1:0] data;
        logic [4:0]   addr;
    } wb_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [4:0]   dest = '0;
    logic         busy;
    logic [N-1:0] wb_data;
    logic [4:0]   wb_addr;
    logic         wb_write;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_count = 0;
    int wr_cyc = 0;
    wb_t sb[$];

    muldiv_writeback_unit #(.N(N)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .dest(dest), .busy(busy), .wb_data(wb_data), .wb_addr(wb_addr), .wb_write(wb_write)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Writeback monitor: pop the scoreboard on every write pulse
    always @(negedge clock) begin
        if (wb_write === 1'b1) begin
            wb_t exp;
            wr_count = wr_count + 1;
            wr_cyc   = cyc;
            checks   = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_write: wb_data=%h wb_addr=%0d, no result expected", wb_data, wb_addr);
            end else begin
                exp = sb.pop_front();
                if (wb_data !== exp.data || wb_addr !== exp.addr) begin
                    errors = errors + 1;
                    $display("FAIL writeback: got data=%h addr=%0d, expected data=%h addr=%0d",
                             wb_data, wb_addr, exp.data, exp.addr);
                end
            end
        end
    end

    // Issue one operation; returns at the negedge after acceptance with inputs scrambled
    task automatic drive_op(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                            input logic [4:0] d, output int acc_cyc);
        @(negedge clock);
        op = o; a = x; b = y; dest = d; start = 1'b1;
        @(posedge clock);
        #1 acc_cyc = cyc;
        @(negedge clock);
        start = 1'b0;
        op = 2'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom}; dest = 5'($urandom);
    endtask

    // Wait (bounded) until the write count moves past cnt0; returns just after a posedge
    task automatic wait_write(input int cnt0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            #1;
            if (wr_count != cnt0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_checked(input string name, input logic [1:0] o, input logic [N-1:0] x,
                               input logic [N-1:0] y, input logic [4:0] d, input logic [N-1:0] exp);
        int acc_cyc;
        int cnt0;
        bit ok;
        cnt0 = wr_count;
        sb.push_back('{data: exp, addr: d});
        drive_op(o, x, y, d, acc_cyc);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy: busy=%b after accept, expected 1", name, busy);
        end
        wait_write(cnt0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: no wb_write within 200 cycles", name);
        end else if (wr_cyc - acc_cyc != LAT) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges, expected %0d", name, wr_cyc - acc_cyc, LAT);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || wb_write !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b wb_write=%b, expected 0 0", name, busy, wb_write);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || wb_write !== 1'b0 || wb_data !== '0 || wb_addr !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b wb_write=%b wb_data=%h wb_addr=%0d, expected all 0",
                     busy, wb_write, wb_data, wb_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_mul();
        run_checked("mul_7x6", 2'b00, 64'd7, 64'd6, 5'd3, 64'd42);
        run_checked("mul_wrap", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE);
        run_checked("mul_signed", 2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd31, 64'hFFFF_FFFF_FFFF_FFF1);
    endtask

    task automatic test_umulh();
        run_checked("umulh_x2", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'd1);
        run_checked("umulh_max", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7,
                    64'hFFFF_FFFF_FFFF_FFFE);
    endtask

    task automatic test_udiv();
        run_checked("udiv_100_7", 2'b10, 64'd100, 64'd7, 5'd9, 64'd14);
        run_checked("udiv_by0", 2'b10, 64'd5, 64'd0, 5'd10, 64'd0);
        run_checked("udiv_big", 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 5'd11, 64'hFFFF_FFFF);
    endtask

    task automatic test_sdiv();
`ifdef MULDIV_SDIV_EN
        run_checked("sdiv_m7_2", 2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFD);
        run_checked("sdiv_minneg", 2'b11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13,
                    64'h8000_0000_0000_0000);
        run_checked("sdiv_100_m7", 2'b11, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd14, 64'hFFFF_FFFF_FFFF_FFF2);
        run_checked("sdiv_by0", 2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 5'd15, 64'd0);
`else
        run_checked("sdiv_m7_2", 2'b11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd12, 64'h7FFF_FFFF_FFFF_FFFC);
        run_checked("sdiv_minneg", 2'b11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 64'd0);
        run_checked("sdiv_100_m7", 2'b11, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd14, 64'd0);
`endif
    endtask

    task automatic test_ignore_start();
        int acc_cyc;
        int cnt0;
        bit ok;
        cnt0 = wr_count;
        sb.push_back('{data: 64'd600, addr: 5'd20});
        drive_op(2'b00, 64'd20, 64'd30, 5'd20, acc_cyc);
        repeat (9) @(negedge clock);
        op = 2'b00; a = 64'd2; b = 64'd2; dest = 5'd21; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_write(cnt0, ok);
        repeat (100) @(negedge clock);
        checks++;
        if (wr_count - cnt0 != 1) begin
            errors++;
            $display("FAIL ignore_start: got %0d writes, expected 1", wr_count - cnt0);
        end
    endtask

    task automatic test_back_to_back();
        int cnt0;
        int first_cyc;
        bit ok;
        cnt0 = wr_count;
        sb.push_back('{data: 64'd25, addr: 5'd1});
        sb.push_back('{data: 64'd42, addr: 5'd2});
        @(negedge clock);
        op = 2'b00; a = 64'd5; b = 64'd5; dest = 5'd1; start = 1'b1;
        @(negedge clock);
        a = 64'd6; b = 64'd7; dest = 5'd2;
        wait_write(cnt0, ok);
        first_cyc = wr_cyc;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        wait_write(cnt0 + 1, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout: second write missing, writes=%0d", wr_count - cnt0);
        end else if (wr_cyc - first_cyc != LAT + 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles between writes, expected %0d", wr_cyc - first_cyc, LAT + 2);
        end
        repeat (80) @(negedge clock);
        checks++;
        if (wr_count - cnt0 != 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d writes, expected 2", wr_count - cnt0);
        end
    endtask

    task automatic test_abort();
        int acc_cyc;
        int cnt0;
        cnt0 = wr_count;
        drive_op(2'b10, 64'd1000, 64'd3, 5'd22, acc_cyc);
        repeat (29) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || wb_write !== 1'b0 || wb_data !== '0) begin
            errors++;
            $display("FAIL abort_reset: busy=%b wb_write=%b wb_data=%h, expected 0 0 0", busy, wb_write, wb_data);
        end
        reset = 1'b0;
        repeat (100) @(negedge clock);
        checks++;
        if (wr_count != cnt0) begin
            errors++;
            $display("FAIL abort_nowrite: got %0d writes, expected 0", wr_count - cnt0);
        end
        run_checked("mul_after_abort", 2'b00, 64'd3, 64'd3, 5'd4, 64'd9);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_umulh();
        test_udiv();
        test_sdiv();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never written, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
